// File: rtl/game_event_ctrl_if.sv
// Event/status bundle between the game logic, game_event_ctrl and the HUD/score block.
// GOD_MODE_EN adds the god_mode input.
interface game_event_ctrl_if;
   logic       start;
   logic       ship_hit;
   logic       enemy_kill;
`ifdef GOD_MODE_EN
   logic       god_mode;
`endif
   logic       health_update;
   logic       current_score_update;
   logic       gameover_signal;
   logic       game_over;
   logic       invulnerable;
   logic [3:0] health_shadow;
   logic [7:0] score_shadow;
   logic [1:0] state;

   modport master (
`ifdef GOD_MODE_EN
      output god_mode,
`endif
      output start, ship_hit, enemy_kill,
      input  health_update, current_score_update, gameover_signal,
      input  game_over, invulnerable, health_shadow, score_shadow, state
   );

   modport slave (
`ifdef GOD_MODE_EN
      input  god_mode,
`endif
      input  start, ship_hit, enemy_kill,
      output health_update, current_score_update, gameover_signal,
      output game_over, invulnerable, health_shadow, score_shadow, state
   );
endinterface

// File: rtl/game_event_ctrl.sv
// Game-session controller: turns raw hit/kill/start levels into single-cycle HUD pulses.
// Optional macro GOD_MODE_EN: god_mode input suppresses hits while in PLAY.
module game_event_ctrl #(
   parameter int MAX_HEALTH    = 5,
   parameter int INVULN_CYCLES = 25000000,
   parameter int TMR_W         = 25
) (
   input  logic             clk,
   input  logic             resetn,
   game_event_ctrl_if.slave ev
);
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      PLAY   = 2'b01,
      INVULN = 2'b10,
      OVER   = 2'b11
   } state_t;

   localparam logic [3:0]       HEALTH_INIT = 4'(MAX_HEALTH);
   localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(INVULN_CYCLES - 1);

   state_t           state_reg, state_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic [3:0]       health_reg, health_next;
   logic [7:0]       score_reg, score_next;
   logic             start_prev_reg, hit_prev_reg, kill_prev_reg;
   logic             health_update_reg, health_update_next;
   logic             score_update_reg, score_update_next;
   logic             gameover_reg, gameover_next;
   logic             game_over_reg, game_over_next;
   logic             invulnerable_reg, invulnerable_next;

   logic start_edge, hit_edge, kill_edge;
   logic hit_taken, kill_scored, reload;

   assign start_edge = ev.start      & ~start_prev_reg;
   assign hit_edge   = ev.ship_hit   & ~hit_prev_reg;
   assign kill_edge  = ev.enemy_kill & ~kill_prev_reg;

`ifdef GOD_MODE_EN
   assign hit_taken = hit_edge & (state_reg == PLAY) & ~ev.god_mode;
`else
   assign hit_taken = hit_edge & (state_reg == PLAY);
`endif
   assign kill_scored = kill_edge & ((state_reg == PLAY) || (state_reg == INVULN))
                        & (score_reg != 8'hFF);
   assign reload      = start_edge & ((state_reg == IDLE) || (state_reg == OVER));

   // Previous-value registers reset high so a level held through reset is not an edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg         <= IDLE;
         timer_reg         <= '0;
         health_reg        <= '0;
         score_reg         <= '0;
         start_prev_reg    <= 1'b1;
         hit_prev_reg      <= 1'b1;
         kill_prev_reg     <= 1'b1;
         health_update_reg <= 1'b0;
         score_update_reg  <= 1'b0;
         gameover_reg      <= 1'b0;
         game_over_reg     <= 1'b0;
         invulnerable_reg  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         timer_reg         <= timer_next;
         health_reg        <= health_next;
         score_reg         <= score_next;
         start_prev_reg    <= ev.start;
         hit_prev_reg      <= ev.ship_hit;
         kill_prev_reg     <= ev.enemy_kill;
         health_update_reg <= health_update_next;
         score_update_reg  <= score_update_next;
         gameover_reg      <= gameover_next;
         game_over_reg     <= game_over_next;
         invulnerable_reg  <= invulnerable_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      case (state_reg)
         IDLE: if (start_edge) state_next = PLAY;
         PLAY: begin
            if (hit_taken) begin
               if (health_reg <= 4'd1) begin
                  state_next = OVER;
               end else begin
                  state_next = INVULN;
                  timer_next = TMR_LOAD;
               end
            end
         end
         // Timer counts INVULN_CYCLES-1 down to 0, giving INVULN_CYCLES cycles of immunity.
         INVULN: begin
            if (timer_reg == '0) state_next = PLAY;
            else                 timer_next = timer_reg - TMR_W'(1);
         end
         OVER: if (start_edge) state_next = PLAY;
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   always_comb begin
      health_next        = health_reg;
      score_next         = score_reg;
      health_update_next = 1'b0;
      score_update_next  = 1'b0;
      gameover_next      = 1'b0;
      if (reload) begin
         health_next = HEALTH_INIT;
         score_next  = '0;
      end
      if (hit_taken) begin
         health_update_next = 1'b1;
         health_next        = (health_reg == 4'd0) ? 4'd0 : health_reg - 4'd1;
         gameover_next      = (health_reg <= 4'd1);
      end
      if (kill_scored) begin
         score_update_next = 1'b1;
         score_next        = score_reg + 8'd1;
      end
      game_over_next    = (state_next == OVER);
      invulnerable_next = (state_next == INVULN);
   end

   assign ev.health_update        = health_update_reg;
   assign ev.current_score_update = score_update_reg;
   assign ev.gameover_signal      = gameover_reg;
   assign ev.game_over            = game_over_reg;
   assign ev.invulnerable         = invulnerable_reg;
   assign ev.health_shadow        = health_reg;
   assign ev.score_shadow         = score_reg;
   assign ev.state                = state_reg;
endmodule

// File: tb/tb_game_event_ctrl.sv
// Bench for game_event_ctrl (MAX_HEALTH=3, INVULN_CYCLES=4): directed scenarios then random
// events, all compared against a cycle-level behavioural model of the game rules.
module tb_game_event_ctrl;
   localparam int MAXH = 3;
   localparam int INV  = 4;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   miscompares = 0;
   int   su_seen = 0;

   // Model state: mode uses the published state codes (0 idle, 1 play, 2 invuln, 3 over).
   int   m_mode, m_health, m_score, m_left;
   bit   p_start, p_hit, p_kill;
   bit   e_hu, e_su, e_go;

   game_event_ctrl_if ev();

   game_event_ctrl #(.MAX_HEALTH(MAXH), .INVULN_CYCLES(INV), .TMR_W(3)) dut (
      .clk(clk), .resetn(resetn), .ev(ev)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_health = 0; m_score = 0; m_left = 0;
      p_start = 1; p_hit = 1; p_kill = 1;
      e_hu = 0; e_su = 0; e_go = 0;
   endtask

   task automatic model_tick(input bit s, input bit h, input bit k);
      bit se, he, ke;
      se = s && !p_start; he = h && !p_hit; ke = k && !p_kill;
      p_start = s; p_hit = h; p_kill = k;
      e_hu = 0; e_su = 0; e_go = 0;
      if ((m_mode == 1 || m_mode == 2) && ke && m_score < 255) begin
         m_score++; e_su = 1;
      end
      if (m_mode == 0 || m_mode == 3) begin
         if (se) begin m_mode = 1; m_health = MAXH; m_score = 0; end
      end else if (m_mode == 1) begin
         if (he) begin
            e_hu = 1; m_health--;
            if (m_health == 0) begin m_mode = 3; e_go = 1; end
            else begin m_mode = 2; m_left = INV; end
         end
      end else begin
         m_left--;
         if (m_left == 0) m_mode = 1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [2:0]  exp_p;
      logic [15:0] exp_l;
      exp_p = {e_hu, e_su, e_go};
      exp_l = {m_mode == 3, m_mode == 2, 4'(m_health), 8'(m_score), 2'(m_mode)};
      vectors++;
      assert ({ev.health_update, ev.current_score_update, ev.gameover_signal} === exp_p)
      else begin
         miscompares++;
         $error("FAIL %s pulses(hu,su,go) observed=%b expected=%b", tag,
                {ev.health_update, ev.current_score_update, ev.gameover_signal}, exp_p);
      end
      vectors++;
      assert ({ev.game_over, ev.invulnerable, ev.health_shadow, ev.score_shadow, ev.state} === exp_l)
      else begin
         miscompares++;
         $error("FAIL %s status(gov,inv,health,score,state) observed=%h expected=%h", tag,
                {ev.game_over, ev.invulnerable, ev.health_shadow, ev.score_shadow, ev.state}, exp_l);
      end
   endtask

   task automatic step(input string tag, input bit s, input bit h, input bit k);
      @(negedge clk);
      ev.start = s; ev.ship_hit = h; ev.enemy_kill = k;
      @(posedge clk);
      model_tick(s, h, k);
      #1;
      if (ev.current_score_update === 1'b1) su_seen++;
      check_all(tag);
   endtask

   // Reset asserted mid-cycle; outputs must clear before the next clock edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      ev.start = 1'b1; ev.ship_hit = 1'b0; ev.enemy_kill = 1'b0;
`ifdef GOD_MODE_EN
      ev.god_mode = 1'b0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      check_all("reset");
      resetn = 1'b1;

      // 1: start held through reset is not an edge
      repeat (3) step("idle_start_held", 1, 0, 0);
      step("start_low", 0, 0, 0);
      step("start_edge", 1, 0, 0);
      // 2: hit, re-hit inside the immunity window
      step("hit1", 1, 1, 0);
      step("inv_a", 1, 0, 0);
      step("hit_in_window", 1, 1, 0);
      repeat (4) step("inv_tail", 1, 0, 0);
      // 3: fresh game, three spaced hits to game over
      async_reset("reset_before_t3");
      step("t3_start_low", 0, 0, 0);
      step("t3_start", 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step("t3_hit", 1, 1, 0);
         repeat (6) step("t3_gap", 1, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         step("over_events", 1, 1, 1);
         step("over_quiet", 1, 0, 0);
      end
      // 4: restart from OVER, simultaneous hit and kill
      step("t4_start_low", 0, 0, 0);
      step("t4_restart", 1, 0, 0);
      step("t4_hit_kill", 1, 1, 1);
      repeat (5) step("t4_tail", 1, 0, 0);
      // 5: score saturation
      async_reset("reset_before_t5");
      step("t5_start_low", 0, 0, 0);
      step("t5_start", 1, 0, 0);
      su_seen = 0;
      for (int i = 0; i < 256; i++) begin
         step("t5_kill", 1, 0, 1);
         step("t5_kill_low", 1, 0, 0);
      end
      vectors++;
      assert (su_seen === 255)
      else begin
         miscompares++;
         $error("FAIL t5_pulse_count observed=%0d expected=255", su_seen);
      end
      // 6: reset in the middle of the immunity window
      step("t6_hit", 1, 1, 0);
      step("t6_inv", 1, 0, 0);
      async_reset("t6_async_reset");

      // Random play, including restarts and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) async_reset("rand_reset");
         step("rand", ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Upstream stage of the HUD/score block. Converts raw, clk-synchronous game events (ship collision, enemy destroyed, start button) into the single-cycle pulses that block consumes: health_update, current_score_update, gameover_signal.
- Owns the game-session FSM, invulnerability window after a hit, shadow health/score counters and score saturation.
- Guarantees the downstream 4-bit health never underflows and the 8-bit score never wraps.

Parameters:
- MAX_HEALTH, 5, health loaded at game start; legal range 1..15.
- INVULN_CYCLES, 25000000, clk cycles of hit immunity after a non-fatal hit (0.5 s at 50 MHz); minimum 1.
- TMR_W, 25, width of the invulnerability timer; must hold INVULN_CYCLES-1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  start/restart request; level input, rising edge acts.
- ship_hit  in  1  collision level from the game logic; rising edge acts.
- enemy_kill  in  1  enemy-destroyed level; rising edge acts.
- health_update  out  1  one-cycle pulse per accepted hit.
- current_score_update  out  1  one-cycle pulse per scored kill.
- gameover_signal  out  1  one-cycle pulse on entry to OVER.
- game_over  out  1  level, high while in OVER.
- invulnerable  out  1  level, high while in INVULN.
- health_shadow  out  4  current health count.
- score_shadow  out  8  current score count.
- state  out  2  IDLE=00, PLAY=01, INVULN=10, OVER=11.

Behaviour:
- All outputs are registered. Reset (async, resetn=0) forces: state=IDLE, all pulses 0, game_over=0, invulnerable=0, health_shadow=0, score_shadow=0, timer=0.
- Edge detection: a previous-value register per input. These registers reset to 1, so an input held high through reset release produces no edge until it has been seen low.
- Latency: an input edge sampled at clock edge N drives its output pulse high for exactly the cycle after edge N. Two consecutive edges always give two distinct pulses.
- IDLE: hits and kills are ignored. A start edge goes to PLAY and loads health_shadow=MAX_HEALTH, score_shadow=0.
- PLAY, hit edge:
  - health_update=1 and health_shadow decrements.
  - If health_shadow was 1: go to OVER, with gameover_signal=1 in the same cycle as the final health_update.
  - Otherwise: go to INVULN and load timer=INVULN_CYCLES-1.
- INVULN:
  - Hit edges are ignored (no pulse, no decrement). Kills are still scored.
  - The timer decrements each cycle. When the timer is 0, go to PLAY on the next edge, so INVULN lasts exactly INVULN_CYCLES cycles.
- Kill edge in PLAY or INVULN:
  - If score_shadow<255: current_score_update=1 and score_shadow increments.
  - At 255 (saturated): no pulse and no change.
- Simultaneous hit and kill in the same cycle: both are processed, and both pulses fire in the same cycle. This includes the fatal hit, where the kill is still scored.
- OVER:
  - game_over=1. Hits and kills are ignored. health_shadow=0; score_shadow is held.
  - A start edge goes to PLAY with reload as from IDLE; gameover_signal does not re-pulse.
- Start edge during PLAY or INVULN: ignored.
- Reset mid-operation: immediate return to the reset values; a pending timer is discarded.
- state encoding 11 is OVER; the unused-state guard is default -> IDLE.

Optional Feature:
- Macro GOD_MODE_EN.
- Defined: adds input port god_mode (1 bit). While god_mode=1 in PLAY, hit edges are ignored entirely: no health_update, no INVULN entry. Kills score normally.
- Undefined: the port does not exist and hits behave as above.

Test Plan (MAX_HEALTH=3, INVULN_CYCLES=4):
1. Reset with start held high, release resetn -> state stays IDLE, no pulses. Drop start, raise start -> state=01, health_shadow=3, score_shadow=0.
2. In PLAY, hit edge -> health_update high exactly 1 cycle, health_shadow=2, invulnerable high for 4 cycles. A second hit inside that window -> no pulse, health_shadow stays 2.
3. Three hits, each spaced beyond the window -> three health_update pulses. gameover_signal coincides with the third; game_over=1, state=11. Further hits/kills -> no pulses.
4. Hit and kill edges in the same cycle while in PLAY -> health_update and current_score_update both high in the same cycle; score_shadow=1.
5. 256 kill edges -> 255 score pulses, score_shadow=255; the 256th produces no pulse.
6. Assert resetn=0 mid-INVULN -> all outputs return to reset values asynchronously, before the next clk edge.
